// File: rtl/fetch_prefetch.sv
// Instruction fetch stage: issues sequential fetches under a credit limit, tags
// responses with their PCs into a DEPTH-entry FIFO, and squashes stale responses on redirect.
module fetch_prefetch #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            override,
    input  logic [XLEN-1:0] newpc,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] STEP  = XLEN'(PC_STEP);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [XLEN-1:0] instr_q [DEPTH];
    logic [XLEN-1:0] pc_q    [DEPTH];

    logic [CW:0] credit_sum;
    logic        req_fire, rsp_acc, drop, push, pop;

    assign credit_sum = {1'b0, inflight_q} + {1'b0, count_q};
    assign req_valid  = rstn & ~override & (credit_sum < DEPTH_W);
    assign req_addr   = fetch_pc_q;
    assign out_valid  = rstn & (count_q != '0);
    assign out_instr  = instr_q[rd_ptr_q];
    assign out_pc     = pc_q[rd_ptr_q];

    assign req_fire = req_valid & req_ready;
    assign rsp_acc  = rsp_valid & (inflight_q != '0);
    assign drop     = rsp_acc & (discard_q != '0);
    assign push     = rsp_acc & ~drop & ~override & (count_q != DEPTH_C);
    assign pop      = out_valid & out_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        discard_d  = discard_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_acc);

        if (override) begin
            fetch_pc_d = newpc;
            rsp_pc_d   = newpc;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            // Every request still outstanding is stale; discard already counts a
            // subset of those, so it is replaced rather than added to.
            discard_d  = inflight_q - CW'(rsp_acc);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + STEP;
            if (drop)     discard_d  = discard_q - CW'(1'b1);
            if (push) begin
                rsp_pc_d = rsp_pc_q + STEP;
                wr_ptr_d = wr_ptr_q + PW'(1'b1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1'b1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            instr_q    <= '{default: '0};
            pc_q       <= '{default: '0};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            if (push) begin
                instr_q[wr_ptr_q] <= rsp_data;
                pc_q[wr_ptr_q]    <= rsp_pc_q;
            end
        end
    end
endmodule
